// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data load/store share one RAM port.
// Data wins by default; a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);

    state_t     state, next_state;
    logic [2:0] starve, next_starve;
    logic       dreq;

    assign dreq = dREN | dWEN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= 3'd0;
        end else begin
            state  <= next_state;
            starve <= next_starve;
        end
    end

    // Arbitration only in IDLE; every grant returns through IDLE so a served request is never replayed.
    always_comb begin
        next_state  = state;
        next_starve = starve;
        case (state)
            IDLE: begin
                if (dreq && !(iREN && starve == LIMIT)) begin
                    next_state = DGRANT;
                    if (iREN)
                        next_starve = (starve == LIMIT) ? starve : starve + 3'd1;
                end else if (iREN) begin
                    next_state  = IGRANT;
                    next_starve = 3'd0;
                end
            end
            IGRANT: begin
                if (ramstate == RAM_ACCESS || !iREN)
                    next_state = IDLE;
            end
            DGRANT: begin
                if (ramstate == RAM_ACCESS || !dreq)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = dstore;
        iload    = ramload;
        dload    = ramload;
        gnt      = state;
        case (state)
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (ramstate == RAM_ACCESS)
                    iwait = 1'b0;
            end
            DGRANT: begin
                // A simultaneous read and write resolves to the write.
                ramaddr = daddr;
                ramWEN  = dWEN;
                ramREN  = dREN & ~dWEN;
                if (ramstate == RAM_ACCESS)
                    dwait = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: fetch, contention, starvation, write priority, abort, reset.
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [1:0]  gnt;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .gnt(gnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        tick(); tick();
        #1;
        chk("rst_gnt",     32'(gnt),     32'd0);
        chk("rst_ramREN",  32'(ramREN),  32'd0);
        chk("rst_ramWEN",  32'(ramWEN),  32'd0);
        chk("rst_ramaddr", ramaddr,      32'd0);
        chk("rst_iwait",   32'(iwait),   32'd1);
        chk("rst_dwait",   32'(dwait),   32'd1);
        nRST = 1'b1;
        tick();

        // Single instruction fetch
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        #1;
        chk("f_idle_gnt",    32'(gnt),    32'd0);
        chk("f_idle_ramREN", 32'(ramREN), 32'd0);
        tick(); #1;
        chk("f_gnt",     32'(gnt),    32'd1);
        chk("f_ramREN",  32'(ramREN), 32'd1);
        chk("f_ramaddr", ramaddr,     32'h40);
        chk("f_iwait1",  32'(iwait),  32'd1);
        tick(); #1;
        chk("f_iwait2",  32'(iwait),  32'd1);
        tick();
        ramstate = ACCESS; ramload = 32'h8C010004;
        #1;
        chk("f_iwait_acc", 32'(iwait), 32'd0);
        chk("f_iload",     iload,      32'h8C010004);
        chk("f_dwait_acc", 32'(dwait), 32'd1);
        tick();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk("f_done_gnt",   32'(gnt),   32'd0);
        chk("f_done_iwait", 32'(iwait), 32'd1);
        tick();

        // Contention: data first, one bubble, then instruction
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
        tick(); #1;
        chk("c_gnt_d",   32'(gnt),        32'd2);
        chk("c_addr_d",  ramaddr,         32'h200);
        chk("c_iwait",   32'(iwait),      32'd1);
        chk("c_starve1", 32'(dut.starve), 32'd1);
        ramstate = ACCESS; ramload = 32'h1234;
        #1;
        chk("c_dwait", 32'(dwait), 32'd0);
        chk("c_dload", dload,      32'h1234);
        tick();
        dREN = 1'b0; ramstate = BUSY;
        #1;
        chk("c_bubble_gnt", 32'(gnt),    32'd0);
        chk("c_bubble_ren", 32'(ramREN), 32'd0);
        tick(); #1;
        chk("c_gnt_i",   32'(gnt),        32'd1);
        chk("c_addr_i",  ramaddr,         32'h44);
        chk("c_starve0", 32'(dut.starve), 32'd0);
        ramstate = ACCESS;
        tick();
        iREN = 1'b0; ramstate = FREE;
        tick();

        // Starvation: four data grants, then instruction forced
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h204; ramstate = ACCESS;
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            chk("s_gnt_d",  32'(gnt),        32'd2);
            chk("s_starve", 32'(dut.starve), 32'(k));
            tick(); #1;
            chk("s_bubble", 32'(gnt),        32'd0);
        end
        tick(); #1;
        chk("s_gnt_i",    32'(gnt),        32'd1);
        chk("s_addr_i",   ramaddr,         32'h48);
        chk("s_iwait",    32'(iwait),      32'd0);
        chk("s_starve_0", 32'(dut.starve), 32'd0);
        tick();
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();

        // Write priority
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
        #1;
        chk("w_idle_store", ramstore, 32'hDEADBEEF);
        tick(); #1;
        chk("w_gnt",    32'(gnt),    32'd2);
        chk("w_ramWEN", 32'(ramWEN), 32'd1);
        chk("w_ramREN", 32'(ramREN), 32'd0);
        chk("w_addr",   ramaddr,     32'h100);
        chk("w_store",  ramstore,    32'hDEADBEEF);
        chk("w_dwait1", 32'(dwait),  32'd1);
        ramstate = ACCESS;
        #1;
        chk("w_dwait0", 32'(dwait), 32'd0);
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        #1;
        chk("w_done_gnt", 32'(gnt),        32'd0);
        chk("w_starve",   32'(dut.starve), 32'd0);
        tick();

        // Abort a data read while RAM is busy
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        tick(); #1;
        chk("a_gnt",    32'(gnt),    32'd2);
        chk("a_ramREN", 32'(ramREN), 32'd1);
        dREN = 1'b0;
        #1;
        chk("a_drop_ren",  32'(ramREN), 32'd0);
        chk("a_drop_wait", 32'(dwait),  32'd1);
        tick(); #1;
        chk("a_idle_gnt",  32'(gnt),    32'd0);
        chk("a_idle_wait", 32'(dwait),  32'd1);
        ramstate = FREE;
        tick();

        // Reset during a data grant with starve raised, then during an instruction grant
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        tick(); #1;
        chk("r_gnt_d",  32'(gnt),        32'd2);
        chk("r_starve", 32'(dut.starve), 32'd1);
        nRST = 1'b0;
        tick(); #1;
        chk("r1_gnt",    32'(gnt),        32'd0);
        chk("r1_starve", 32'(dut.starve), 32'd0);
        chk("r1_dwait",  32'(dwait),      32'd1);
        nRST = 1'b1; dREN = 1'b0;
        tick(); #1;
        chk("r_gnt_i",  32'(gnt),    32'd1);
        chk("r_ren_i",  32'(ramREN), 32'd1);
        nRST = 1'b0;
        tick(); #1;
        chk("r2_gnt",     32'(gnt),        32'd0);
        chk("r2_ramREN",  32'(ramREN),     32'd0);
        chk("r2_ramaddr", ramaddr,         32'd0);
        chk("r2_iwait",   32'(iwait),      32'd1);
        chk("r2_starve",  32'(dut.starve), 32'd0);
        nRST = 1'b1; iREN = 1'b0; ramstate = FREE;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive data grants with iREN pending before instruction gets forced priority.
REQ-002 SHALL have port CLK  in  1  system clock, rising edge.
REQ-003 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port iREN  in  1  instruction read request.
REQ-005 SHALL have port iaddr  in  32  instruction address.
REQ-006 SHALL have port dREN  in  1  data read request.
REQ-007 SHALL have port dWEN  in  1  data write request.
REQ-008 SHALL have port daddr  in  32  data address.
REQ-009 SHALL have port dstore  in  32  data write value.
REQ-010 SHALL have port iwait  out  1  instruction stall, low for exactly the completion cycle.
REQ-011 SHALL have port dwait  out  1  data stall, low for exactly the completion cycle.
REQ-012 SHALL have port iload  out  32  instruction read data.
REQ-013 SHALL have port dload  out  32  data read data.
REQ-014 SHALL have port ramREN  out  1  RAM read strobe.
REQ-015 SHALL have port ramWEN  out  1  RAM write strobe.
REQ-016 SHALL have port ramaddr  out  32  RAM address.
REQ-017 SHALL have port ramstore  out  32  RAM write data.
REQ-018 SHALL have port ramload  in  32  RAM read data.
REQ-019 SHALL have port ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 SHALL have port gnt  out  2  current state: IDLE=0, IGRANT=1, DGRANT=2.

Function
REQ-021 SHALL implement a registered FSM with states IDLE, IGRANT, DGRANT; arbitration happens only in IDLE, so the first RAM strobe occurs one cycle after a request is first seen.
REQ-022 IDLE: if (dREN|dWEN) and not (iREN and starve==STARVE_LIMIT), next state DGRANT; else if iREN, next IGRANT; else stay IDLE.
REQ-023 DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins when both are high).
REQ-024 IGRANT: ramaddr=iaddr, ramREN=iREN, ramWEN=0.
REQ-025 IDLE: ramREN=ramWEN=0, ramaddr=0; ramstore always equals dstore.
REQ-026 Completion: ramstate==ACCESS in DGRANT drives dwait=0; in IGRANT it drives iwait=0; both are combinational, same cycle; next state IDLE (mandatory one-cycle bubble, so a request already served is never served twice).
REQ-027 iwait/dwait SHALL be 1 in every other cycle, including IDLE and while the other requester holds the grant.
REQ-028 iload=ramload and dload=ramload, always (pass-through; valid only on the completion cycle).
REQ-029 ramstate FREE, BUSY or ERROR SHALL hold the current grant state; ERROR is treated as BUSY.
REQ-030 Abort: in DGRANT with dREN=dWEN=0, or in IGRANT with iREN=0, RAM strobes drop the same cycle and next state is IDLE.
REQ-031 starve counter, 3 bits: on each IDLE->DGRANT transition with iREN=1, increment, saturating at STARVE_LIMIT; on IDLE->IGRANT, clear to 0; otherwise hold.
REQ-032 When starve==STARVE_LIMIT and iREN=1 in IDLE, IGRANT SHALL win even if a data request is present.
REQ-033 gnt SHALL reflect the registered state.

Reset
REQ-034 nRST low at a rising edge SHALL force state IDLE and starve 0 at that edge, including mid-transaction.
REQ-035 During and after reset until next grant: ramREN=ramWEN=0, ramaddr=0, iwait=dwait=1, gnt=0.

Verification
REQ-036 Single fetch: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C010004 -> gnt=1 at cycle 1; iwait=0 and iload=0x8C010004 only on the ACCESS cycle; gnt=0 next cycle.
REQ-037 Contention: iREN=dREN=1 in the same cycle -> DGRANT first (ramaddr=daddr); after completion, one IDLE cycle; then IGRANT.
REQ-038 Starvation: iREN held, dREN re-asserted every IDLE, ACCESS immediately -> 4 DGRANTs; 5th grant is IGRANT; starve returns to 0.
REQ-039 Write priority: dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ACCESS.
REQ-040 Abort: in DGRANT with ramstate BUSY, drop dREN -> ramREN=0 same cycle; gnt=0 next cycle; dwait never low.
REQ-041 Reset mid-transaction: nRST=0 during IGRANT BUSY -> gnt=0, ramREN=0, iwait=1 after the edge; starve=0.
